// File: rtl/riscv_pipe_pkg.sv
// Shared types for the ID/EX boundary of the 64-bit pipeline: the ID/EX register
// payload and the operand forwarding select encoding.
package riscv_pipe_pkg;

   localparam int XLEN       = 64;
   localparam int REG_ADDR_W = 5;
   localparam int CTRL_W     = 16;

   typedef enum logic [1:0] {
      FWD_ZERO = 2'd0,
      FWD_MEM  = 2'd1,
      FWD_WB   = 2'd2,
      FWD_RF   = 2'd3
   } fwd_sel_e;

   typedef struct packed {
      logic [XLEN-1:0]       op_a;
      logic [XLEN-1:0]       op_b;
      logic [XLEN-1:0]       imm;
      logic [XLEN-1:0]       pc;
      logic [REG_ADDR_W-1:0] rd;
      logic                  regwrite;
      logic                  is_load;
      logic [CTRL_W-1:0]     ctrl;
   } id_ex_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Combinational forwarding select for one source operand.
// The WB leg exists only when ORS_WB_BYPASS_EN is defined.
module operand_fwd_mux
   import riscv_pipe_pkg::*;
#(
   parameter int DATA_WIDTH    = XLEN,
   parameter int ADDRESS_WIDTH = REG_ADDR_W
) (
   input  logic [ADDRESS_WIDTH-1:0] rs,
   input  logic [DATA_WIDTH-1:0]    rf_data,
   input  logic                     mem_regwrite,
   input  logic [ADDRESS_WIDTH-1:0] mem_rd,
   input  logic [DATA_WIDTH-1:0]    mem_result,
   input  logic                     wb_regwrite,
   input  logic [ADDRESS_WIDTH-1:0] wb_rd,
   input  logic [DATA_WIDTH-1:0]    wb_data,
   output logic [DATA_WIDTH-1:0]    operand
);

   fwd_sel_e sel_s;

`ifndef ORS_WB_BYPASS_EN
   // Without the bypass the register file commits on the falling edge, so rf_data already carries WB.
   logic unused_wb_s;
   assign unused_wb_s = ^{wb_regwrite, wb_rd, wb_data};
`endif

   // Priority select: x0, then the younger MEM result, then WB, then the register file
   always_comb begin
      sel_s = FWD_RF;
      if (rs == {ADDRESS_WIDTH{1'b0}}) begin
         sel_s = FWD_ZERO;
      end else if (mem_regwrite && (mem_rd == rs)) begin
         sel_s = FWD_MEM;
`ifdef ORS_WB_BYPASS_EN
      end else if (wb_regwrite && (wb_rd == rs)) begin
         sel_s = FWD_WB;
`endif
      end else begin
         sel_s = FWD_RF;
      end
   end

   // Operand data steering
   always_comb begin
      operand = {DATA_WIDTH{1'b0}};
      case (sel_s)
         FWD_ZERO: operand = {DATA_WIDTH{1'b0}};
         FWD_MEM:  operand = mem_result;
`ifdef ORS_WB_BYPASS_EN
         FWD_WB:   operand = wb_data;
`else
         FWD_WB:   operand = rf_data;
`endif
         FWD_RF:   operand = rf_data;
         default:  operand = {DATA_WIDTH{1'b0}};
      endcase
   end

endmodule

// File: rtl/operand_read_stage.sv
// ID->EX operand read stage: regfile addressing, MEM/WB forwarding, load-use bubbles and
// the ID/EX register with valid/ready toward EX. Optional WB bypass: ORS_WB_BYPASS_EN.
module operand_read_stage
   import riscv_pipe_pkg::*;
#(
   parameter int DATA_WIDTH    = XLEN,
   parameter int ADDRESS_WIDTH = REG_ADDR_W,
   parameter int CTRL_WIDTH    = CTRL_W
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     id_valid,
   output logic                     id_ready,
   input  logic [ADDRESS_WIDTH-1:0] id_rs1,
   input  logic [ADDRESS_WIDTH-1:0] id_rs2,
   input  logic [ADDRESS_WIDTH-1:0] id_rd,
   input  logic                     id_use_rs1,
   input  logic                     id_use_rs2,
   input  logic                     id_regwrite,
   input  logic                     id_is_load,
   input  logic [DATA_WIDTH-1:0]    id_imm,
   input  logic [DATA_WIDTH-1:0]    id_pc,
   input  logic [CTRL_WIDTH-1:0]    id_ctrl,
   output logic [ADDRESS_WIDTH-1:0] ra1,
   output logic [ADDRESS_WIDTH-1:0] ra2,
   input  logic [DATA_WIDTH-1:0]    rd1,
   input  logic [DATA_WIDTH-1:0]    rd2,
   input  logic                     mem_regwrite,
   input  logic [ADDRESS_WIDTH-1:0] mem_rd,
   input  logic [DATA_WIDTH-1:0]    mem_result,
   input  logic                     wb_regwrite,
   input  logic [ADDRESS_WIDTH-1:0] wb_rd,
   input  logic [DATA_WIDTH-1:0]    wb_data,
   input  logic                     flush,
   input  logic                     ex_ready,
   output logic                     ex_valid,
   output logic [DATA_WIDTH-1:0]    ex_op_a,
   output logic [DATA_WIDTH-1:0]    ex_op_b,
   output logic [DATA_WIDTH-1:0]    ex_imm,
   output logic [DATA_WIDTH-1:0]    ex_pc,
   output logic [ADDRESS_WIDTH-1:0] ex_rd,
   output logic                     ex_regwrite,
   output logic                     ex_is_load,
   output logic [CTRL_WIDTH-1:0]    ex_ctrl
);

   logic [DATA_WIDTH-1:0] op_a_s;
   logic [DATA_WIDTH-1:0] op_b_s;
   logic                  hazard_s;
   logic                  id_ready_s;
   logic                  accept_s;
   id_ex_t                next_s;
   id_ex_t                stage_r;
   logic                  valid_r;

   assign ra1 = id_rs1;
   assign ra2 = id_rs2;

   operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH)) u_fwd_a (
      .rs           (id_rs1),
      .rf_data      (rd1),
      .mem_regwrite (mem_regwrite),
      .mem_rd       (mem_rd),
      .mem_result   (mem_result),
      .wb_regwrite  (wb_regwrite),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .operand      (op_a_s)
   );

   operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH)) u_fwd_b (
      .rs           (id_rs2),
      .rf_data      (rd2),
      .mem_regwrite (mem_regwrite),
      .mem_rd       (mem_rd),
      .mem_result   (mem_result),
      .wb_regwrite  (wb_regwrite),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .operand      (op_b_s)
   );

   // A load in the ID/EX register has no data until MEM, so a dependent reader waits one cycle
   always_comb begin
      hazard_s = 1'b0;
      if (valid_r && stage_r.is_load && (stage_r.rd != {ADDRESS_WIDTH{1'b0}})) begin
         hazard_s = (id_use_rs1 && (id_rs1 == stage_r.rd)) ||
                    (id_use_rs2 && (id_rs2 == stage_r.rd));
      end else begin
         hazard_s = 1'b0;
      end
   end

   assign id_ready_s = !hazard_s && (!valid_r || ex_ready);
   assign accept_s   = id_valid && id_ready_s;
   assign id_ready   = id_ready_s;

   // Payload presented to the ID/EX register on an accepting edge
   always_comb begin
      next_s          = stage_r;
      next_s.op_a     = op_a_s;
      next_s.op_b     = op_b_s;
      next_s.imm      = id_imm;
      next_s.pc       = id_pc;
      next_s.rd       = id_rd;
      next_s.regwrite = id_regwrite;
      next_s.is_load  = id_is_load;
      next_s.ctrl     = id_ctrl;
   end

   // ID/EX register: flush beats capture, capture beats drain, otherwise hold for EX
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_r <= 1'b0;
         stage_r <= id_ex_t'({$bits(id_ex_t){1'b0}});
      end else if (flush) begin
         valid_r <= 1'b0;
      end else if (accept_s) begin
         valid_r <= 1'b1;
         stage_r <= next_s;
      end else if (ex_ready) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign ex_valid    = valid_r;
   assign ex_op_a     = stage_r.op_a;
   assign ex_op_b     = stage_r.op_b;
   assign ex_imm      = stage_r.imm;
   assign ex_pc       = stage_r.pc;
   assign ex_rd       = stage_r.rd;
   assign ex_regwrite = stage_r.regwrite;
   assign ex_is_load  = stage_r.is_load;
   assign ex_ctrl     = stage_r.ctrl;

endmodule

// File: tb/tb_operand_read_stage.sv
// Randomized plus directed bench for operand_read_stage against a cycle-level reference model.
module tb_operand_read_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        id_valid, id_ready;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_use_rs1, id_use_rs2, id_regwrite, id_is_load;
   logic [63:0] id_imm, id_pc;
   logic [15:0] id_ctrl;
   logic [4:0]  ra1, ra2;
   logic [63:0] rd1, rd2;
   logic        mem_regwrite;
   logic [4:0]  mem_rd;
   logic [63:0] mem_result;
   logic        wb_regwrite;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        flush, ex_ready, ex_valid;
   logic [63:0] ex_op_a, ex_op_b, ex_imm, ex_pc;
   logic [4:0]  ex_rd;
   logic        ex_regwrite, ex_is_load;
   logic [15:0] ex_ctrl;

   logic [63:0] regs [32];
   logic        m_valid, m_rw, m_ld;
   logic [63:0] m_a, m_b, m_imm, m_pc;
   logic [4:0]  m_rd;
   logic [15:0] m_ctrl;
   int          n_total = 0;
   int          n_bad   = 0;

   operand_read_stage dut (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_ready(id_ready),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_regwrite(id_regwrite), .id_is_load(id_is_load),
      .id_imm(id_imm), .id_pc(id_pc), .id_ctrl(id_ctrl),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
      .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
      .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm), .ex_pc(ex_pc),
      .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .ex_ctrl(ex_ctrl)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Register file as seen by the stage; without the bypass it commits WB before the capture edge
   function automatic logic [63:0] rf_read(input logic [4:0] a);
`ifndef ORS_WB_BYPASS_EN
      if (wb_regwrite && wb_rd == a && a != 5'd0) return wb_data;
`endif
      return regs[a];
   endfunction

   // Architectural value an instruction must see for source register a
   function automatic logic [63:0] ref_operand(input logic [4:0] a);
      if (a == 5'd0) return 64'd0;
      if (mem_regwrite && mem_rd == a) return mem_result;
      if (wb_regwrite && wb_rd == a) return wb_data;
      return regs[a];
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_rw = 1'b0; m_ld = 1'b0; m_a = 64'd0; m_b = 64'd0;
      m_imm = 64'd0; m_pc = 64'd0; m_rd = 5'd0; m_ctrl = 16'd0;
   endtask

   task automatic idle();
      id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
      id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_regwrite = 1'b0; id_is_load = 1'b0;
      id_imm = 64'd0; id_pc = 64'd0; id_ctrl = 16'd0;
      mem_regwrite = 1'b0; mem_rd = 5'd0; mem_result = 64'd0;
      wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = 64'd0;
      flush = 1'b0; ex_ready = 1'b1;
   endtask

   // One clock: inputs already set after a falling edge; returns at the next falling edge
   task automatic step();
      logic hz, rdy;
      rd1 = rf_read(id_rs1);
      rd2 = rf_read(id_rs2);
      #1;
      hz  = m_valid && m_ld && (m_rd != 5'd0) &&
            ((id_use_rs1 && id_rs1 == m_rd) || (id_use_rs2 && id_rs2 == m_rd));
      rdy = !hz && (!m_valid || ex_ready);
      chk("ra1", 64'(ra1), 64'(id_rs1));
      chk("ra2", 64'(ra2), 64'(id_rs2));
      if (!flush) chk("id_ready", 64'(id_ready), 64'(rdy));
      @(posedge clk);
      if (flush) begin
         m_valid = 1'b0;
      end else if (id_valid && rdy) begin
         m_valid = 1'b1; m_a = ref_operand(id_rs1); m_b = ref_operand(id_rs2);
         m_imm = id_imm; m_pc = id_pc; m_rd = id_rd; m_rw = id_regwrite;
         m_ld = id_is_load; m_ctrl = id_ctrl;
      end else if (ex_ready) begin
         m_valid = 1'b0;
      end
      #1;
      chk("ex_valid", 64'(ex_valid), 64'(m_valid));
      if (m_valid) begin
         chk("ex_op_a", ex_op_a, m_a);
         chk("ex_op_b", ex_op_b, m_b);
         chk("ex_imm", ex_imm, m_imm);
         chk("ex_pc", ex_pc, m_pc);
         chk("ex_rd", 64'(ex_rd), 64'(m_rd));
         chk("ex_regwrite", 64'(ex_regwrite), 64'(m_rw));
         chk("ex_is_load", 64'(ex_is_load), 64'(m_ld));
         chk("ex_ctrl", 64'(ex_ctrl), 64'(m_ctrl));
      end
      @(negedge clk);
   endtask

   task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic is_load, input logic [63:0] pc);
      id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; id_regwrite = 1'b1; id_is_load = is_load;
      id_imm = pc ^ 64'h5a5a; id_pc = pc; id_ctrl = pc[15:0];
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 64'd0 : {$urandom, $urandom};
      idle();
      model_reset();
      reset_n = 1'b0;
      rd1 = 64'd0; rd2 = 64'd0;
      @(negedge clk); @(negedge clk);
      chk("reset_valid", 64'(ex_valid), 64'd0);
      chk("reset_op_a", ex_op_a, 64'd0);
      chk("reset_pc", ex_pc, 64'd0);
      chk("reset_ctrl", 64'(ex_ctrl), 64'd0);
      reset_n = 1'b1;

      // MEM result wins over WB and the register file
      regs[5] = 64'h11;
      set_instr(5'd5, 5'd0, 5'd9, 1'b0, 64'h1000);
      mem_regwrite = 1'b1; mem_rd = 5'd5; mem_result = 64'hAA;
      wb_regwrite = 1'b1; wb_rd = 5'd5; wb_data = 64'hBB;
      step();
      chk("mem_fwd", ex_op_a, 64'hAA);
      // x0 is never forwarded
      idle();
      set_instr(5'd3, 5'd0, 5'd4, 1'b0, 64'h1004);
      mem_regwrite = 1'b1; mem_rd = 5'd0; mem_result = 64'hFF;
      wb_regwrite = 1'b1; wb_rd = 5'd0; wb_data = 64'hEE;
      step();
      chk("x0_op_b", ex_op_b, 64'd0);

      // Asynchronous reset mid-stream with a valid instruction held
      idle(); ex_ready = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_valid", 64'(ex_valid), 64'd0);
      chk("async_rst_op_a", ex_op_a, 64'd0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      idle();

      // Load-use: exactly one bubble, then the add sees the loaded value via WB
      set_instr(5'd1, 5'd2, 5'd7, 1'b1, 64'h2000);
      step();
      set_instr(5'd7, 5'd3, 5'd8, 1'b0, 64'h2004);
      step();
      chk("lu_bubble", 64'(ex_valid), 64'd0);
      wb_regwrite = 1'b1; wb_rd = 5'd7; wb_data = 64'h77;
      step();
      chk("lu_capture", 64'(ex_valid), 64'd1);
      chk("lu_fwd", ex_op_a, 64'h77);

      // Backpressure: three held cycles, then same-cycle accept on release
      idle();
      set_instr(5'd2, 5'd3, 5'd4, 1'b0, 64'h3000);
      step();
      set_instr(5'd5, 5'd6, 5'd9, 1'b0, 64'h3004);
      ex_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_hold_pc", ex_pc, 64'h3000);
      end
      ex_ready = 1'b1;
      step();
      chk("bp_accept_pc", ex_pc, 64'h3004);

      // Flush while a load-use stall is pending, then no extra stall
      idle();
      set_instr(5'd1, 5'd2, 5'd7, 1'b1, 64'h4000);
      step();
      set_instr(5'd7, 5'd3, 5'd8, 1'b0, 64'h4004);
      flush = 1'b1;
      step();
      chk("flush_valid", 64'(ex_valid), 64'd0);
      flush = 1'b0;
      step();
      chk("post_flush_capture", 64'(ex_valid), 64'd1);
      chk("post_flush_pc", ex_pc, 64'h4004);

      // Randomized traffic over a small register window to provoke hazards and forwarding
      for (int c = 0; c < 600; c++) begin
         regs[$urandom_range(1, 31)] = {$urandom, $urandom};
         id_valid     = ($urandom_range(0, 9) < 8);
         id_rs1       = 5'($urandom_range(0, 7));
         id_rs2       = 5'($urandom_range(0, 7));
         id_rd        = 5'($urandom_range(0, 7));
         id_use_rs1   = ($urandom_range(0, 3) != 0);
         id_use_rs2   = ($urandom_range(0, 1) != 0);
         id_regwrite  = ($urandom_range(0, 3) != 0);
         id_is_load   = ($urandom_range(0, 2) == 0);
         id_imm       = {$urandom, $urandom};
         id_pc        = {$urandom, $urandom};
         id_ctrl      = 16'($urandom);
         mem_regwrite = ($urandom_range(0, 1) != 0);
         mem_rd       = 5'($urandom_range(0, 7));
         mem_result   = {$urandom, $urandom};
         wb_regwrite  = ($urandom_range(0, 1) != 0);
         wb_rd        = 5'($urandom_range(0, 7));
         wb_data      = {$urandom, $urandom};
         flush        = ($urandom_range(0, 15) == 0);
         ex_ready     = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
